// File: rtl/gen_case_serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// gen_case_serial_sub_pkg : FSM encodings, default sizes, digit-width helper
// Rev 1.0
// ============================================================================
package gen_case_serial_sub_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DEF_N = 8;
  localparam int DEF_D = 1;

  // Unsupported digit widths collapse to a single-bit slice.
  function automatic int digit_w(input int d);
    case (d)
      2:       return 2;
      4:       return 4;
      default: return 1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/gen_case_serial_sub_digit.sv
`default_nettype none
// ============================================================================
// gen_case_serial_sub_digit : W-bit ripple-borrow subtract slice, {bo,d}=a-b-bi
// Rev 1.0
// ============================================================================
module gen_case_serial_sub_digit
  import gen_case_serial_sub_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_bin,
  output logic [W-1:0] o_d,
  output logic         o_bout
);

  logic [W:0] w_brw;

  assign w_brw[0] = i_bin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_d[i]       = i_a[i] ^ i_b[i] ^ w_brw[i];
    assign w_brw[i + 1] = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_brw[i]);
  end

  assign o_bout = w_brw[W];

endmodule
`default_nettype wire

// File: rtl/gen_case_serial_sub.sv
`default_nettype none
// ============================================================================
// gen_case_serial_sub : digit-serial unsigned subtractor, LSB first, start/done
// Rev 1.0
// ============================================================================
module gen_case_serial_sub
  import gen_case_serial_sub_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int D = DEF_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         borrow_in,
  output logic [N-1:0] diff,
  output logic         borrow_out,
  output logic         busy,
  output logic         done
);

  localparam int c_DW   = digit_w(D);
  localparam int c_NDIG = N / c_DW;
  localparam int c_CW   = $clog2(c_NDIG) + 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NDIG - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_res;
  logic            r_brw;
  logic [c_CW-1:0] r_cnt;
  logic [N-1:0]    r_diff;
  logic            r_bout;

  logic [c_DW-1:0] w_d;
  logic            w_bnext;
  logic [N-1:0]    w_res_next;
  logic            w_accept;
  logic            w_last;

  // Exactly one slice is elaborated; its width always equals c_DW.
  generate
    case (D)
      2: begin : g_d2
        gen_case_serial_sub_digit #(.W(2)) u_digit (
          .i_a(r_a[c_DW-1:0]), .i_b(r_b[c_DW-1:0]), .i_bin(r_brw),
          .o_d(w_d), .o_bout(w_bnext)
        );
      end
      4: begin : g_d4
        gen_case_serial_sub_digit #(.W(4)) u_digit (
          .i_a(r_a[c_DW-1:0]), .i_b(r_b[c_DW-1:0]), .i_bin(r_brw),
          .o_d(w_d), .o_bout(w_bnext)
        );
      end
      default: begin : g_d1
        gen_case_serial_sub_digit #(.W(1)) u_digit (
          .i_a(r_a[c_DW-1:0]), .i_b(r_b[c_DW-1:0]), .i_bin(r_brw),
          .o_d(w_d), .o_bout(w_bnext)
        );
      end
    endcase
  endgenerate

  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last     = (r_cnt == c_LAST);
  assign w_res_next = (r_res >> c_DW) | (N'(w_d) << (N - c_DW));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= in1;
      r_b   <= in2;
      r_brw <= borrow_in;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> c_DW;
      r_b   <= r_b >> c_DW;
      r_res <= w_res_next;
      r_brw <= w_bnext;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_res_next;
        r_bout <= w_bnext;
      end
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_bout;

endmodule
`default_nettype wire
